// File: rtl/output_display_buffer.sv
// Output display buffer: captures processor output changes into a 4-entry FIFO
// and shows the head entry on a 2-digit seven-segment display. Macro: OUTBUF_OVERFLOW_OVERWRITE_EN.
module output_display_buffer #(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] proc_out,
    input  logic       proc_halt,
    input  logic       next,
    output logic [6:0] seg,
    output logic [1:0] digit_en,
    output logic [2:0] count,
    output logic       full,
    output logic       overflow,
    output logic       halted
);

    typedef logic [REFRESH_DIV-1:0] refresh_t;

    logic [7:0] mem [4];
    logic [1:0] head;
    logic [1:0] tail;
    logic [7:0] prev;
    logic       next_d;
    refresh_t   refresh;

    logic       capture;
    logic       pop;
    logic       wr;
    logic       adv_head;
    logic       ovf;
    logic [3:0] nib;

    assign capture = (proc_out != prev);
    assign pop     = next && !next_d && (count != 3'd0);
    assign full    = (count == 3'd4);

    // Decide FIFO actions; a pop frees a slot so a coincident capture always fits.
    always_comb begin
        wr       = 1'b0;
        adv_head = pop;
        ovf      = 1'b0;
        if (capture) begin
            if (pop || !full) begin
                wr = 1'b1;
            end else begin
                ovf = 1'b1;
`ifdef OUTBUF_OVERFLOW_OVERWRITE_EN
                wr       = 1'b1;
                adv_head = 1'b1;
`else
                wr       = 1'b0;
                adv_head = 1'b0;
`endif
            end
        end
    end

    // FIFO storage is never reset; count==0 hides stale contents.
    always_ff @(posedge clk) begin
        if (!reset && wr) begin
            mem[tail] <= proc_out;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= 2'd0;
            tail     <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (wr) begin
                tail <= tail + 2'd1;
            end
            if (adv_head) begin
                head <= head + 2'd1;
            end
            if (wr && !adv_head) begin
                count <= count + 3'd1;
            end else if (adv_head && !wr) begin
                count <= count - 3'd1;
            end
            if (ovf) begin
                overflow <= 1'b1;
            end
        end
    end

    // Input history registers and the sticky halt flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev   <= 8'h00;
            next_d <= 1'b0;
            halted <= 1'b0;
        end else begin
            prev   <= proc_out;
            next_d <= next;
            if (proc_halt) begin
                halted <= 1'b1;
            end
        end
    end

    // Free-running refresh counter; digit select flips each time it wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh  <= '0;
            digit_en <= 2'b01;
        end else begin
            refresh <= refresh + refresh_t'(1);
            if (&refresh) begin
                digit_en <= ~digit_en;
            end
        end
    end

    // Segment decode follows digit_en combinationally so they never skew.
    always_comb begin
        nib = digit_en[1] ? mem[head][7:4] : mem[head][3:0];
        seg = 7'h40;
        if (count != 3'd0) begin
            case (nib)
                4'h0: seg = 7'h3F;
                4'h1: seg = 7'h06;
                4'h2: seg = 7'h5B;
                4'h3: seg = 7'h4F;
                4'h4: seg = 7'h66;
                4'h5: seg = 7'h6D;
                4'h6: seg = 7'h7D;
                4'h7: seg = 7'h07;
                4'h8: seg = 7'h7F;
                4'h9: seg = 7'h6F;
                4'hA: seg = 7'h77;
                4'hB: seg = 7'h7C;
                4'hC: seg = 7'h39;
                4'hD: seg = 7'h5E;
                4'hE: seg = 7'h79;
                default: seg = 7'h71;
            endcase
        end
    end

endmodule

// File: tb/tb_output_display_buffer.sv
// Testbench for output_display_buffer: queue scoreboard of captured bytes,
// popped and compared against the displayed head entry.
module tb_output_display_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] proc_out;
    logic       proc_halt;
    logic       next;
    logic [6:0] seg;
    logic [1:0] digit_en;
    logic [2:0] count;
    logic       full;
    logic       overflow;
    logic       halted;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] q[$];

    output_display_buffer dut (
        .clk(clk), .reset(reset), .proc_out(proc_out),
        .proc_halt(proc_halt), .next(next), .seg(seg),
        .digit_en(digit_en), .count(count), .full(full),
        .overflow(overflow), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    function automatic logic [6:0] exp_seg(input logic [7:0] b, input logic [1:0] de);
        return de[1] ? hex7(b[7:4]) : hex7(b[3:0]);
    endfunction

    // Apply inputs at a falling edge, let one rising edge pass, return at next falling edge.
    task automatic cyc(input logic [7:0] po, input logic nx, input logic ph);
        proc_out  = po;
        next      = nx;
        proc_halt = ph;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        q.delete();
    endtask

    task automatic test_reset;
        logic [1:0] exp_de;
        do_reset();
        n_cmp++;
        if ({count, full, overflow, halted, seg, digit_en} !==
            {3'd0, 1'b0, 1'b0, 1'b0, 7'h40, 2'b01}) begin
            n_bad++;
            $display("FAIL reset_state: got cnt=%0d full=%b ovf=%b hlt=%b seg=%h de=%b want 0/0/0/0/40/01",
                     count, full, overflow, halted, seg, digit_en);
        end
        for (int k = 1; k <= 32; k++) begin
            cyc(8'h00, 1'b0, 1'b0);
            exp_de = (((k / 16) % 2) == 1) ? 2'b10 : 2'b01;
            n_cmp++;
            if ({digit_en, seg, count} !== {exp_de, 7'h40, 3'd0}) begin
                n_bad++;
                $display("FAIL refresh_k%0d: got de=%b seg=%h cnt=%0d want de=%b seg=40 cnt=0",
                         k, digit_en, seg, count, exp_de);
            end
        end
    endtask

    task automatic test_capture_display;
        bit seen_lo = 0;
        bit seen_hi = 0;
        cyc(8'h3C, 1'b0, 1'b0);
        q.push_back(8'h3C);
        n_cmp++;
        if (count !== 3'd1) begin
            n_bad++;
            $display("FAIL capture_latency: got cnt=%0d want 1", count);
        end
        for (int k = 0; k < 40 && !(seen_lo && seen_hi); k++) begin
            if (digit_en == 2'b01 && !seen_lo) begin
                seen_lo = 1;
                n_cmp++;
                if (seg !== 7'h39) begin
                    n_bad++;
                    $display("FAIL digit_lo: got seg=%h want 39", seg);
                end
            end else if (digit_en == 2'b10 && !seen_hi) begin
                seen_hi = 1;
                n_cmp++;
                if (seg !== 7'h4F) begin
                    n_bad++;
                    $display("FAIL digit_hi: got seg=%h want 4F", seg);
                end
            end
            cyc(8'h3C, 1'b0, 1'b0);
        end
        n_cmp++;
        if (!(seen_lo && seen_hi)) begin
            n_bad++;
            $display("FAIL digit_scan: got lo=%b hi=%b want both seen", seen_lo, seen_hi);
        end
        cyc(8'h3C, 1'b1, 1'b0);
        void'(q.pop_front());
        cyc(8'h3C, 1'b0, 1'b0);
        n_cmp++;
        if ({count, seg} !== {3'd0, 7'h40}) begin
            n_bad++;
            $display("FAIL capture_pop: got cnt=%0d seg=%h want 0/40", count, seg);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] vals [5];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        foreach (vals[i]) begin
            cyc(vals[i], 1'b0, 1'b0);
            if (q.size() < 4) begin
                q.push_back(vals[i]);
            end else begin
`ifdef OUTBUF_OVERFLOW_OVERWRITE_EN
                void'(q.pop_front());
                q.push_back(vals[i]);
`endif
            end
        end
        n_cmp++;
        if ({count, full, overflow} !== {3'd4, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL overflow_state: got cnt=%0d full=%b ovf=%b want 4/1/1",
                     count, full, overflow);
        end
        for (int g = 0; g < 8 && q.size() > 0; g++) begin
            n_cmp++;
            if (seg !== exp_seg(q[0], digit_en)) begin
                n_bad++;
                $display("FAIL overflow_head: got seg=%h want %h (byte %h)",
                         seg, exp_seg(q[0], digit_en), q[0]);
            end
            cyc(8'h55, 1'b1, 1'b0);
            void'(q.pop_front());
            cyc(8'h55, 1'b0, 1'b0);
            n_cmp++;
            if (count !== 3'(q.size())) begin
                n_bad++;
                $display("FAIL overflow_drain: got cnt=%0d want %0d", count, q.size());
            end
        end
    endtask

    task automatic test_pop;
        cyc(8'h66, 1'b0, 1'b0);
        q.push_back(8'h66);
        cyc(8'h77, 1'b0, 1'b0);
        q.push_back(8'h77);
        n_cmp++;
        if (count !== 3'd2) begin
            n_bad++;
            $display("FAIL pop_fill: got cnt=%0d want 2", count);
        end
        for (int k = 0; k < 10; k++) cyc(8'h77, 1'b1, 1'b0);
        void'(q.pop_front());
        n_cmp++;
        if ({count, seg} !== {3'd1, exp_seg(q[0], digit_en)}) begin
            n_bad++;
            $display("FAIL pop_held: got cnt=%0d seg=%h want 1/%h",
                     count, seg, exp_seg(q[0], digit_en));
        end
        cyc(8'h77, 1'b0, 1'b0);
        cyc(8'h77, 1'b1, 1'b0);
        void'(q.pop_front());
        cyc(8'h77, 1'b0, 1'b0);
        cyc(8'h77, 1'b1, 1'b0);
        cyc(8'h77, 1'b0, 1'b0);
        n_cmp++;
        if ({count, seg} !== {3'd0, 7'h40}) begin
            n_bad++;
            $display("FAIL pop_empty: got cnt=%0d seg=%h want 0/40", count, seg);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cyc(8'(i), 1'b0, 1'b0);
            q.push_back(8'(i));
        end
        n_cmp++;
        if ({count, full, overflow} !== {3'd4, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_fill: got cnt=%0d full=%b ovf=%b want 4/1/0", count, full, overflow);
        end
        cyc(8'h05, 1'b1, 1'b0);
        void'(q.pop_front());
        q.push_back(8'h05);
        n_cmp++;
        if ({count, overflow} !== {3'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_simul: got cnt=%0d ovf=%b want 4/0", count, overflow);
        end
        for (int g = 0; g < 8 && q.size() > 0; g++) begin
            cyc(8'h05, 1'b0, 1'b0);
            n_cmp++;
            if (seg !== exp_seg(q[0], digit_en)) begin
                n_bad++;
                $display("FAIL b2b_head: got seg=%h want %h (byte %h)",
                         seg, exp_seg(q[0], digit_en), q[0]);
            end
            cyc(8'h05, 1'b1, 1'b0);
            void'(q.pop_front());
        end
        cyc(8'h05, 1'b0, 1'b0);
        cyc(8'h06, 1'b1, 1'b0);
        q.push_back(8'h06);
        cyc(8'h06, 1'b0, 1'b0);
        n_cmp++;
        if ({count, seg} !== {3'd1, exp_seg(q[0], digit_en)}) begin
            n_bad++;
            $display("FAIL empty_simul: got cnt=%0d seg=%h want 1/%h",
                     count, seg, exp_seg(q[0], digit_en));
        end
        cyc(8'h06, 1'b1, 1'b0);
        void'(q.pop_front());
        cyc(8'h06, 1'b0, 1'b0);
    endtask

    task automatic test_halt_reset;
        logic [7:0] vals [5];
        vals = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        n_cmp++;
        if (halted !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_idle: got %b want 0", halted);
        end
        cyc(8'h06, 1'b0, 1'b1);
        n_cmp++;
        if (halted !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_set: got %b want 1", halted);
        end
        foreach (vals[i]) cyc(vals[i], 1'b0, 1'b0);
        n_cmp++;
        if ({halted, overflow, count} !== {1'b1, 1'b1, 3'd4}) begin
            n_bad++;
            $display("FAIL halt_hold: got hlt=%b ovf=%b cnt=%0d want 1/1/4", halted, overflow, count);
        end
        reset = 1'b1;
        cyc(8'hB6, 1'b1, 1'b0);
        n_cmp++;
        if ({count, overflow, halted, seg, digit_en} !== {3'd0, 1'b0, 1'b0, 7'h40, 2'b01}) begin
            n_bad++;
            $display("FAIL mid_reset: got cnt=%0d ovf=%b hlt=%b seg=%h de=%b want 0/0/0/40/01",
                     count, overflow, halted, seg, digit_en);
        end
        cyc(8'hB6, 1'b0, 1'b0);
        reset = 1'b0;
        q.delete();
        cyc(8'hB6, 1'b0, 1'b0);
        q.push_back(8'hB6);
        n_cmp++;
        if ({count, seg} !== {3'd1, exp_seg(q[0], digit_en)}) begin
            n_bad++;
            $display("FAIL post_reset_capture: got cnt=%0d seg=%h want 1/%h",
                     count, seg, exp_seg(q[0], digit_en));
        end
    endtask

    initial begin
        reset     = 1'b1;
        proc_out  = 8'h00;
        proc_halt = 1'b0;
        next      = 1'b0;
        @(negedge clk);
        test_reset();
        test_capture_display();
        test_overflow();
        test_pop();
        test_back_to_back();
        test_halt_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
